// File: rtl/turn_signal_monitor.sv
// Checking end for the tail-light lamp bus: decodes the two lamp patterns into
// direction/level/sweep count and latches a coded fault on any illegal transition.
// Optional TURN_MON_INPUT_REG_EN adds one register stage on all inputs.
module turn_signal_monitor #(
    parameter int DWELL   = 3,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         left_signal,
    input  logic [2:0]         right_signal,
    input  logic               error_in,
    input  logic               clear_fault,
    output logic [1:0]         direction,
    output logic [1:0]         level,
    output logic               hazard,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [COUNT_W-1:0] sweep_count
);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);

    typedef enum logic [2:0] {
        S_IDLE, S_LEFT_TRK, S_RIGHT_TRK, S_HAZARD, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE = 3'd0, FC_ENC = 3'd1, FC_BOTH = 3'd2, FC_SIDE = 3'd3,
        FC_SKIP = 3'd4, FC_SHORT = 3'd5, FC_LONG = 3'd6
    } fcode_t;

    logic [2:0] l_sig, r_sig;
    logic       err, clr;

`ifdef TURN_MON_INPUT_REG_EN
    logic [2:0] l_sig_q, r_sig_q;
    logic       err_q, clr_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            l_sig_q <= '0;
            r_sig_q <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            l_sig_q <= left_signal;
            r_sig_q <= right_signal;
            err_q   <= error_in;
            clr_q   <= clear_fault;
        end
    end
    assign l_sig = l_sig_q;
    assign r_sig = r_sig_q;
    assign err   = err_q;
    assign clr   = clr_q;
`else
    assign l_sig = left_signal;
    assign r_sig = right_signal;
    assign err   = error_in;
    assign clr   = clear_fault;
`endif

    // Lamps fill from the inside out, so each side has its own thermometer code
    logic [1:0] l_lvl, r_lvl;
    logic       l_bad, r_bad;
    always_comb begin
        l_bad = 1'b0;
        case (l_sig)
            3'b000:  l_lvl = 2'd0;
            3'b001:  l_lvl = 2'd1;
            3'b011:  l_lvl = 2'd2;
            3'b111:  l_lvl = 2'd3;
            default: begin l_lvl = 2'd0; l_bad = 1'b1; end
        endcase
        r_bad = 1'b0;
        case (r_sig)
            3'b000:  r_lvl = 2'd0;
            3'b100:  r_lvl = 2'd1;
            3'b110:  r_lvl = 2'd2;
            3'b111:  r_lvl = 2'd3;
            default: begin r_lvl = 2'd0; r_bad = 1'b1; end
        endcase
    end

    state_t             state_q, state_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [1:0]         cur_q, cur_d;
    logic [1:0]         prev_q, prev_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         lvl_q, lvl_d;
    logic               haz_q, haz_d;
    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;
    logic [COUNT_W-1:0] sweep_q, sweep_d;

    logic [1:0] trk_lvl, oth_lvl;
    fcode_t     viol;

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        dir_d   = dir_q;
        lvl_d   = lvl_q;
        haz_d   = 1'b0;
        fault_d = fault_q;
        code_d  = code_q;
        sweep_d = sweep_q;
        viol    = FC_NONE;
        trk_lvl = (state_q == S_RIGHT_TRK) ? r_lvl : l_lvl;
        oth_lvl = (state_q == S_RIGHT_TRK) ? l_lvl : r_lvl;

        if (state_q == S_FAULT) begin
            if (clr && l_sig == 3'b000 && r_sig == 3'b000) begin
                state_d = S_IDLE;
                fault_d = 1'b0;
                code_d  = FC_NONE;
            end
        end else if (l_bad || r_bad) begin
            viol = FC_ENC;
        end else if (l_lvl != 2'd0 && r_lvl != 2'd0) begin
            viol = FC_BOTH;
        end else if (state_q == S_HAZARD && (l_lvl != 2'd0 || r_lvl != 2'd0)) begin
            viol = FC_BOTH;
        end else if (err) begin
            state_d = S_HAZARD;
            haz_d   = 1'b1;
            dir_d   = 2'b00;
            lvl_d   = 2'd0;
            dwell_d = '0;
            cur_d   = 2'd0;
            prev_d  = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dir_d = 2'b00;
                    lvl_d = 2'd0;
                    if (l_lvl == 2'd1 || r_lvl == 2'd1) begin
                        state_d = (l_lvl == 2'd1) ? S_LEFT_TRK : S_RIGHT_TRK;
                        dir_d   = (l_lvl == 2'd1) ? 2'b01 : 2'b10;
                        lvl_d   = 2'd1;
                        cur_d   = 2'd1;
                        prev_d  = 2'd1;
                        dwell_d = DW'(1);
                    end else if (l_lvl != 2'd0 || r_lvl != 2'd0) begin
                        viol = FC_SKIP;
                    end
                end
                S_HAZARD: begin
                    state_d = S_IDLE;
                    dir_d   = 2'b00;
                    lvl_d   = 2'd0;
                end
                S_LEFT_TRK, S_RIGHT_TRK: begin
                    if (oth_lvl != 2'd0) begin
                        viol = FC_SIDE;
                    end else if (cur_q == 2'd0) begin
                        // single permitted zero cycle between sweeps
                        if (trk_lvl == 2'd0) begin
                            state_d = S_IDLE;
                            dir_d   = 2'b00;
                            lvl_d   = 2'd0;
                            dwell_d = '0;
                            prev_d  = 2'd0;
                        end else if (trk_lvl == 2'd1 && prev_q == 2'd3) begin
                            cur_d   = 2'd1;
                            prev_d  = 2'd1;
                            lvl_d   = 2'd1;
                            dwell_d = DW'(1);
                        end else begin
                            viol = FC_SKIP;
                        end
                    end else if (trk_lvl == cur_q) begin
                        if (dwell_q < DWELL_MAX) dwell_d = dwell_q + DW'(1);
                        else                     viol    = FC_LONG;
                    end else if (trk_lvl != 2'd0 &&
                                 {1'b0, trk_lvl} != {1'b0, cur_q} + 3'd1) begin
                        viol = FC_SKIP;
                    end else if (dwell_q != DWELL_MAX) begin
                        viol = FC_SHORT;
                    end else begin
                        cur_d = trk_lvl;
                        lvl_d = trk_lvl;
                        if (trk_lvl == 2'd0) begin
                            dwell_d = '0;
                            if (cur_q == 2'd3) sweep_d = sweep_q + COUNT_W'(1);
                        end else begin
                            dwell_d = DW'(1);
                            prev_d  = trk_lvl;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (viol != FC_NONE) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = viol;
            dir_d   = 2'b00;
            lvl_d   = 2'd0;
            haz_d   = 1'b0;
            dwell_d = '0;
            cur_d   = 2'd0;
            prev_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
            cur_q   <= 2'd0;
            prev_q  <= 2'd0;
            dir_q   <= 2'b00;
            lvl_q   <= 2'd0;
            haz_q   <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 3'd0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            dir_q   <= dir_d;
            lvl_q   <= lvl_d;
            haz_q   <= haz_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            sweep_q <= sweep_d;
        end
    end

    assign direction   = dir_q;
    assign level       = lvl_q;
    assign hazard      = haz_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign sweep_count = sweep_q;
endmodule

// File: tb/tb_turn_signal_monitor.sv
// Directed vector table plus a long sweep-counter wrap sequence for
// turn_signal_monitor (default build, DWELL=3, COUNT_W=8).
module tb_turn_signal_monitor;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] left_signal, right_signal;
    logic       error_in, clear_fault;
    logic [1:0] direction, level;
    logic       hazard, fault;
    logic [2:0] fault_code;
    logic [7:0] sweep_count;

    turn_signal_monitor #(.DWELL(3), .COUNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .left_signal(left_signal), .right_signal(right_signal),
        .error_in(error_in), .clear_fault(clear_fault),
        .direction(direction), .level(level), .hazard(hazard),
        .fault(fault), .fault_code(fault_code), .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] l, r;
        logic       e, c, rs;
        logic [1:0] d, lv;
        logic       h, f;
        logic [2:0] code;
        logic [7:0] sw;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic vec(input int n, input logic [2:0] l, r, input logic e, c, rs,
                       input logic [1:0] d, lv, input logic h, f,
                       input logic [2:0] code, input logic [7:0] sw);
        vec_t v;
        v.l = l; v.r = r; v.e = e; v.c = c; v.rs = rs;
        v.d = d; v.lv = lv; v.h = h; v.f = f; v.code = code; v.sw = sw;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // drive one sample and return after the edge that registers it
    task automatic apply(input logic [2:0] l, r, input logic e, c, rs);
        left_signal = l; right_signal = r; error_in = e; clear_fault = c;
        reset_n = ~rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] d, lv,
                         input logic h, f, input logic [2:0] code, input logic [7:0] sw);
        n_cmp++;
        if (direction !== d || level !== lv || hazard !== h || fault !== f ||
            fault_code !== code || sweep_count !== sw) begin
            n_bad++;
            $display("FAIL %s: got dir=%b lvl=%0d haz=%b flt=%b code=%0d sw=%0d, want dir=%b lvl=%0d haz=%b flt=%b code=%0d sw=%0d",
                     name, direction, level, hazard, fault, fault_code, sweep_count,
                     d, lv, h, f, code, sw);
        end
    endtask

    initial begin
        reset_n = 1'b0; left_signal = '0; right_signal = '0;
        error_in = 1'b0; clear_fault = 1'b0;
        @(posedge clk); #1;

        //      n  left    right   e c rs  dir   lv h f code sw
        vec(1, 3'b000, 3'b000, 0,0,1, 2'b00, 0, 0,0, 0, 0);
        // clean left run, two sweeps
        vec(2, 3'b000, 3'b000, 0,0,0, 2'b00, 0, 0,0, 0, 0);
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 0);
        vec(3, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 0);
        vec(3, 3'b111, 3'b000, 0,0,0, 2'b01, 3, 0,0, 0, 0);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b01, 0, 0,0, 0, 1);
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 1);
        vec(3, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 1);
        vec(3, 3'b111, 3'b000, 0,0,0, 2'b01, 3, 0,0, 0, 1);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b01, 0, 0,0, 0, 2);
        vec(2, 3'b000, 3'b000, 0,0,0, 2'b00, 0, 0,0, 0, 2);
        // right run, 110 held too long, then activity ignored while in fault
        vec(3, 3'b000, 3'b100, 0,0,0, 2'b10, 1, 0,0, 0, 2);
        vec(3, 3'b000, 3'b110, 0,0,0, 2'b10, 2, 0,0, 0, 2);
        vec(1, 3'b000, 3'b110, 0,0,0, 2'b00, 0, 0,1, 6, 2);
        vec(1, 3'b000, 3'b111, 0,0,0, 2'b00, 0, 0,1, 6, 2);
        vec(1, 3'b010, 3'b000, 0,0,0, 2'b00, 0, 0,1, 6, 2);
        vec(1, 3'b000, 3'b000, 1,0,0, 2'b00, 0, 0,1, 6, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // both sides lit outranks side violation; clear outside fault is inert
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 2);
        vec(1, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 2);
        vec(1, 3'b011, 3'b100, 0,0,0, 2'b00, 0, 0,1, 2, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // illegal encoding; clear with lamps lit keeps the fault
        vec(1, 3'b010, 3'b000, 0,0,0, 2'b00, 0, 0,1, 1, 2);
        vec(1, 3'b001, 3'b000, 0,1,0, 2'b00, 0, 0,1, 1, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // hazard during right sweep, then skip from idle
        vec(3, 3'b000, 3'b100, 0,0,0, 2'b10, 1, 0,0, 0, 2);
        vec(1, 3'b000, 3'b110, 0,0,0, 2'b10, 2, 0,0, 0, 2);
        vec(5, 3'b000, 3'b000, 1,0,0, 2'b00, 0, 1,0, 0, 2);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b00, 0, 0,0, 0, 2);
        vec(1, 3'b000, 3'b110, 0,0,0, 2'b00, 0, 0,1, 4, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // reset mid-sequence, clean restart
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 2);
        vec(1, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 2);
        vec(1, 3'b011, 3'b000, 0,0,1, 2'b00, 0, 0,0, 0, 0);
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 0);
        vec(3, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 0);
        vec(3, 3'b111, 3'b000, 0,0,0, 2'b01, 3, 0,0, 0, 0);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b01, 0, 0,0, 0, 1);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b00, 0, 0,0, 0, 1);
        // dwell too short
        vec(2, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 1);
        vec(1, 3'b011, 3'b000, 0,0,0, 2'b00, 0, 0,1, 5, 1);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 1);
        // other side lights during the zero cycle
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 1);
        vec(3, 3'b011, 3'b000, 0,0,0, 2'b01, 2, 0,0, 0, 1);
        vec(3, 3'b111, 3'b000, 0,0,0, 2'b01, 3, 0,0, 0, 1);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b01, 0, 0,0, 0, 2);
        vec(1, 3'b000, 3'b100, 0,0,0, 2'b00, 0, 0,1, 3, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // wrap to level 1 after a partial sweep is a skip
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 2);
        vec(1, 3'b000, 3'b000, 0,0,0, 2'b01, 0, 0,0, 0, 2);
        vec(1, 3'b001, 3'b000, 0,0,0, 2'b00, 0, 0,1, 4, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // jump 1 -> 3 at full dwell
        vec(3, 3'b001, 3'b000, 0,0,0, 2'b01, 1, 0,0, 0, 2);
        vec(1, 3'b111, 3'b000, 0,0,0, 2'b00, 0, 0,1, 4, 2);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 2);
        // first sample after reset at level 3
        vec(1, 3'b000, 3'b000, 0,0,1, 2'b00, 0, 0,0, 0, 0);
        vec(1, 3'b111, 3'b000, 0,0,0, 2'b00, 0, 0,1, 4, 0);
        vec(1, 3'b000, 3'b000, 0,1,0, 2'b00, 0, 0,0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].l, vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].rs);
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].lv, vecs[i].h,
                  vecs[i].f, vecs[i].code, vecs[i].sw);
        end

        // 257 back-to-back left sweeps: counter must wrap modulo 256
        apply(3'b000, 3'b000, 0, 0, 1);
        for (int k = 1; k <= 257; k++) begin
            for (int j = 0; j < 3; j++) apply(3'b001, 3'b000, 0, 0, 0);
            for (int j = 0; j < 3; j++) apply(3'b011, 3'b000, 0, 0, 0);
            for (int j = 0; j < 3; j++) apply(3'b111, 3'b000, 0, 0, 0);
            apply(3'b000, 3'b000, 0, 0, 0);
            check($sformatf("sweep%0d", k), 2'b01, 2'd0, 1'b0, 1'b0, 3'd0, 8'(k % 256));
        end
        apply(3'b000, 3'b000, 0, 0, 0);
        check("sweep_idle", 2'b00, 2'd0, 1'b0, 1'b0, 3'd0, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
